ram_arbiter: RTL and testbench

Arbiter and sequencer for the single-port synchronous RAM in the KANADE32 core. It shares the RAM between three requesters: the instruction-fetch port, the data-access (memory stage) port, and an external program-loader port. Each requester uses a req/ack handshake. The arbiter replaces direct PC/ALU-result muxing onto the RAM address and serialises all accesses with a fixed read/write latency.

---
 rtl/ram_arbiter.sv | 93 +++++++++
 tb/tb_ram_arbiter.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter.sv
// ram_arbiter: three-port req/ack arbiter and sequencer for the single-port synchronous RAM
module ram_arbiter #(
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_ack,
    output logic [31:0] if_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_ack,
    output logic [31:0] d_rdata,
    input  logic        ld_req,
    input  logic        ld_we,
    input  logic [31:0] ld_addr,
    input  logic [31:0] ld_wdata,
    output logic        ld_ack,
    output logic [31:0] ld_rdata,
    input  logic        ld_lock,
    output logic [1:0]  owner,
    output logic        busy,
    output logic [29:0] ram_addr,
    output logic [31:0] ram_data,
    output logic        ram_wren,
    input  logic [31:0] ram_q
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    localparam logic [3:0] SMAX = 4'(STARVE_MAX);
    state_t      state, state_nx;
    logic [1:0]  owner_nx, win;
    logic [29:0] addr_nx;
    logic [31:0] data_nx;
    logic        wren_nx, arb, if_el, d_el, ld_el;
    logic [3:0]  starve_cnt, starve_nx;
    logic        unused_addr_bits;
    assign unused_addr_bits = ^{if_addr[1:0], d_addr[1:0], ld_addr[1:0]};
    assign busy     = state != IDLE;
    assign if_ack   = state == RESP && owner == 2'd1;
    assign d_ack    = state == RESP && owner == 2'd2;
    assign ld_ack   = state == RESP && owner == 2'd3;
    assign if_rdata = ram_q;
    assign d_rdata  = ram_q;
    assign ld_rdata = ram_q;
    always_comb begin
        arb       = state == IDLE || state == RESP;
        // the port being acked this cycle sits out the overlapping arbitration
        if_el     = if_req & ~ld_lock & ~(state == RESP && owner == 2'd1);
        d_el      = d_req & ~ld_lock & ~(state == RESP && owner == 2'd2);
        ld_el     = ld_req & ~(state == RESP && owner == 2'd3);
        win       = ld_el ? 2'd3 : (d_el && !(if_el && starve_cnt == SMAX)) ? 2'd2 : if_el ? 2'd1 : 2'd0;
        state_nx  = state;
        owner_nx  = owner;
        addr_nx   = ram_addr;
        data_nx   = ram_data;
        wren_nx   = 1'b0;
        if (arb) begin
            state_nx = win != 2'd0 ? ACCESS : IDLE;
            owner_nx = win;
            if (win != 2'd0) begin
                addr_nx = win == 2'd3 ? ld_addr[31:2] : win == 2'd2 ? d_addr[31:2] : if_addr[31:2];
                data_nx = win == 2'd3 ? ld_wdata : win == 2'd2 ? d_wdata : ram_data;
                wren_nx = win == 2'd3 ? ld_we : win == 2'd2 ? d_we : 1'b0;
            end
        end else if (state == ACCESS) begin
            state_nx = RESP;
        end
        starve_nx = !if_req ? 4'd0 :
                    (!arb || win == 2'd0) ? starve_cnt :
                    win == 2'd1 ? 4'd0 :
                    (if_el && starve_cnt != SMAX) ? starve_cnt + 4'd1 : starve_cnt;
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            owner      <= 2'd0;
            ram_addr   <= 30'd0;
            ram_data   <= 32'd0;
            ram_wren   <= 1'b0;
            starve_cnt <= 4'd0;
        end else begin
            state      <= state_nx;
            owner      <= owner_nx;
            ram_addr   <= addr_nx;
            ram_data   <= data_nx;
            ram_wren   <= wren_nx;
            starve_cnt <= starve_nx;
        end
    end
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed checks of ram_arbiter against a behavioural single-port RAM
module tb_ram_arbiter;
    logic        clk = 1'b0, reset_n = 1'b0;
    logic        if_req = 1'b0, if_ack;
    logic [31:0] if_addr = '0, if_rdata;
    logic        d_req = 1'b0, d_we = 1'b0, d_ack;
    logic [31:0] d_addr = '0, d_wdata = '0, d_rdata;
    logic        ld_req = 1'b0, ld_we = 1'b0, ld_ack, ld_lock = 1'b0;
    logic [31:0] ld_addr = '0, ld_wdata = '0, ld_rdata;
    logic [1:0]  owner;
    logic        busy, ram_wren;
    logic [29:0] ram_addr;
    logic [31:0] ram_data, ram_q;
    logic [31:0] mem [256];
    logic        pre_we = 1'b0;
    logic [7:0]  pre_a = '0;
    logic [31:0] pre_d = '0;
    int n_cmp = 0, n_err = 0;

    ram_arbiter #(.STARVE_MAX(2)) dut (
        .clk(clk), .reset_n(reset_n),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_ack(d_ack), .d_rdata(d_rdata),
        .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata), .ld_ack(ld_ack), .ld_rdata(ld_rdata),
        .ld_lock(ld_lock), .owner(owner), .busy(busy),
        .ram_addr(ram_addr), .ram_data(ram_data), .ram_wren(ram_wren), .ram_q(ram_q)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_wren) mem[ram_addr[7:0]] <= ram_data;
        else if (pre_we) mem[pre_a] <= pre_d;
        ram_q <= mem[ram_addr[7:0]];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic preload(input logic [7:0] a, input logic [31:0] d);
        pre_we = 1'b1; pre_a = a; pre_d = d;
        tick();
        pre_we = 1'b0;
    endtask

    initial begin
        tick(2);
        check("rst_owner", 32'(owner), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_wren", 32'(ram_wren), 0);
        check("rst_addr", 32'(ram_addr), 0);
        check("rst_data", ram_data, 0);
        check("rst_acks", 32'({if_ack, d_ack, ld_ack}), 0);
        reset_n = 1'b1;
        tick();
        preload(8'd4, 32'hDEADBEEF);
        preload(8'd9, 32'h11111111);
        tick();

        // single fetch
        if_req = 1'b1; if_addr = 32'h10;
        tick();
        check("f_addr", 32'(ram_addr), 4);
        check("f_wren", 32'(ram_wren), 0);
        check("f_owner", 32'(owner), 1);
        check("f_noack", 32'(if_ack), 0);
        tick();
        check("f_ack", 32'(if_ack), 1);
        check("f_rdata", if_rdata, 32'hDEADBEEF);
        if_req = 1'b0;
        tick();
        check("f_busy", 32'(busy), 0);

        // simultaneous data write and fetch read of the same word
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h20; d_wdata = 32'h12345678;
        if_req = 1'b1; if_addr = 32'h20;
        tick();
        check("s_wren", 32'(ram_wren), 1);
        check("s_addr", 32'(ram_addr), 8);
        tick();
        check("s_dack", 32'(d_ack), 1);
        check("s_ifack2", 32'(if_ack), 0);
        d_req = 1'b0; d_we = 1'b0;
        tick();
        check("s_wren3", 32'(ram_wren), 0);
        tick();
        check("s_ifack", 32'(if_ack), 1);
        check("s_rdata", if_rdata, 32'h12345678);
        if_req = 1'b0;
        tick();

        // starvation: loader, data and fetch all pending, STARVE_MAX=2
        ld_req = 1'b1; ld_addr = 32'h20;
        d_req = 1'b1; d_addr = 32'h10;
        if_req = 1'b1; if_addr = 32'h20;
        tick(2);
        check("st_ld1", 32'({ld_ack, d_ack, if_ack}), 32'b100);
        tick(2);
        check("st_d1", 32'({ld_ack, d_ack, if_ack}), 32'b010);
        tick(2);
        check("st_ld2", 32'({ld_ack, d_ack, if_ack}), 32'b100);
        ld_req = 1'b0;
        tick();
        check("st_owner", 32'(owner), 1);
        tick();
        check("st_if", 32'({ld_ack, d_ack, if_ack}), 32'b001);
        check("st_if_rd", if_rdata, 32'h12345678);
        if_req = 1'b0;
        tick(2);
        check("st_d2", 32'(d_ack), 1);
        check("st_d_rd", d_rdata, 32'hDEADBEEF);
        d_req = 1'b0;
        tick();

        // loader lock: fetch held off while loader fills words 0..3
        ld_lock = 1'b1; if_req = 1'b1; if_addr = 32'h0;
        for (int i = 0; i < 4; i++) begin
            ld_req = 1'b1; ld_we = 1'b1; ld_addr = 32'(i * 4); ld_wdata = 32'hA5A5A5A5;
            tick();
            check("lk_if_busy", 32'(if_ack), 0);
            tick();
            check("lk_ldack", 32'(ld_ack), 1);
            check("lk_noif", 32'(if_ack), 0);
            ld_req = 1'b0; ld_we = 1'b0;
            if (i == 3) ld_lock = 1'b0;
            else begin
                tick();
                check("lk_idle_owner", 32'(owner), 0);
            end
        end
        tick(2);
        check("lk_ifack", 32'(if_ack), 1);
        check("lk_rdata", if_rdata, 32'hA5A5A5A5);
        if_req = 1'b0;
        tick();

        // reset during a write in ACCESS
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h24; d_wdata = 32'hCAFEF00D;
        tick();
        check("r_wren_pre", 32'(ram_wren), 1);
        reset_n = 1'b0;
        #1;
        check("r_wren", 32'(ram_wren), 0);
        check("r_owner", 32'(owner), 0);
        check("r_busy", 32'(busy), 0);
        d_req = 1'b0; d_we = 1'b0;
        tick();
        check("r_noack", 32'(d_ack), 0);
        reset_n = 1'b1;
        tick();
        if_req = 1'b1; if_addr = 32'h24;
        tick(2);
        check("r_ifack", 32'(if_ack), 1);
        check("r_keep", if_rdata, 32'h11111111);
        if_req = 1'b0;
        tick();

        // idle stress
        for (int i = 0; i < 100; i++) begin
            check("idle", 32'({ram_wren, if_ack, d_ack, ld_ack, owner, busy}), 0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
